// File: rtl/cdb_arbiter.sv
// cdb_arbiter: registered round-robin arbiter and broadcast stage for the
// common data bus. Requesters 0..3 are ALU, multiplier, divider, load/store.
// The grant (requireAC) is combinational in the request cycle; the broadcast
// (BCEN/BCdata/BClabel/grant_idx) comes from flops one cycle later.
// Optional macro CDB_FIXED_PRIO_EN: ties the search pointer to 0, giving
// fixed priority with index 0 highest.
module cdb_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 4
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic [N_REQ-1:0]           require,
    input  logic [N_REQ*DATA_W-1:0]    data_in,
    input  logic [N_REQ*LABEL_W-1:0]   label_in,
    output logic [N_REQ-1:0]           requireAC,
    output logic                       BCEN,
    output logic [DATA_W-1:0]          BCdata,
    output logic [LABEL_W-1:0]         BClabel,
    output logic [1:0]                 grant_idx
);

    localparam int PTR_W = 2;

    logic [PTR_W-1:0]   ptr;
    logic [N_REQ-1:0]   eligible;
    logic               win_valid;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    logic [DATA_W-1:0]  win_data;
    logic [LABEL_W-1:0] win_label;

    // Index base+off wrapped modulo the number of requesters.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int off);
        int sum;
        sum = (int'(base) + off) % N_REQ;
        return sum[PTR_W-1:0];
    endfunction

    // A request carrying label 0 has no producer tag and is never eligible.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = require[i] && (label_in[i*LABEL_W +: LABEL_W] != '0);
        end
    end

    // Search upward from ptr; the first eligible requester wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        requireAC = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = wrap_idx(ptr, k);
            if (!win_valid && eligible[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
        if (win_valid) begin
            requireAC[win_idx] = 1'b1;
        end
    end

    assign win_data  = data_in[int'(win_idx)*DATA_W +: DATA_W];
    assign win_label = label_in[int'(win_idx)*LABEL_W +: LABEL_W];

`ifdef CDB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    // Rotate the pointer past the winner so every requester gets a turn.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ptr <= '0;
        end else if (win_valid) begin
            ptr <= wrap_idx(win_idx, 1);
        end
    end
`endif

    // Register the winner's result onto the CDB; hold payload when idle.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            BCEN      <= 1'b0;
            BCdata    <= '0;
            BClabel   <= '0;
            grant_idx <= '0;
        end else begin
            BCEN <= win_valid;
            if (win_valid) begin
                BCdata    <= win_data;
                BClabel   <= win_label;
                grant_idx <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: self-checking bench for cdb_arbiter. A behavioural model
// (search from a pointer over eligible requests, registered broadcast) runs
// alongside directed scenarios and a randomized request stream.
module tb_cdb_arbiter;

    localparam int N_REQ   = 4;
    localparam int DATA_W  = 32;
    localparam int LABEL_W = 4;

    logic                     clk  = 1'b0;
    logic                     nRST = 1'b1;
    logic [N_REQ-1:0]         require  = '0;
    logic [N_REQ*DATA_W-1:0]  data_in  = '0;
    logic [N_REQ*LABEL_W-1:0] label_in = '0;
    logic [N_REQ-1:0]         requireAC;
    logic                     BCEN;
    logic [DATA_W-1:0]        BCdata;
    logic [LABEL_W-1:0]       BClabel;
    logic [1:0]               grant_idx;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int                 m_ptr;
    logic               m_bcen;
    logic [DATA_W-1:0]  m_data;
    logic [LABEL_W-1:0] m_label;
    logic [1:0]         m_gidx;

    cdb_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .LABEL_W(LABEL_W)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .require   (require),
        .data_in   (data_in),
        .label_in  (label_in),
        .requireAC (requireAC),
        .BCEN      (BCEN),
        .BCdata    (BCdata),
        .BClabel   (BClabel),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    function automatic int model_pick(input logic [N_REQ-1:0] req,
                                      input logic [N_REQ*LABEL_W-1:0] lab,
                                      input int base);
        for (int k = 0; k < N_REQ; k++) begin
            int i;
            i = (base + k) % N_REQ;
            if (req[i] && lab[i*LABEL_W +: LABEL_W] != '0) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_bcen  = 1'b0;
        m_data  = '0;
        m_label = '0;
        m_gidx  = '0;
    endtask

    // Drive one cycle: sample the grant mid-cycle, clock, update the model.
    // Returns #1 after the rising edge.
    task automatic run_cycle(input logic [N_REQ-1:0] req,
                             input logic [N_REQ*DATA_W-1:0] d,
                             input logic [N_REQ*LABEL_W-1:0] l,
                             output logic [N_REQ-1:0] obs_ac,
                             output logic [N_REQ-1:0] exp_ac);
        int w;
        require  = req;
        data_in  = d;
        label_in = l;
        @(negedge clk);
        obs_ac = requireAC;
        w = model_pick(req, l, m_ptr);
        exp_ac = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        @(posedge clk);
        #1;
        if (w >= 0) begin
            m_bcen  = 1'b1;
            m_data  = d[w*DATA_W +: DATA_W];
            m_label = l[w*LABEL_W +: LABEL_W];
            m_gidx  = 2'(w);
`ifndef CDB_FIXED_PRIO_EN
            m_ptr   = (w + 1) % N_REQ;
`endif
        end else begin
            m_bcen = 1'b0;
        end
    endtask

    task automatic apply_reset();
        require = '0;
        nRST = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        logic [N_REQ-1:0] oac, eac;
        logic [N_REQ*DATA_W-1:0] d;
        d = {32'h4444_0000, 32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
        require  = 4'b1111;
        label_in = {4'd4, 4'd3, 4'd2, 4'd9};
        data_in  = d;
        nRST = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({BCEN, BCdata, BClabel, grant_idx} !== 39'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outs: got %b/%h/%h/%0d expected 0/0/0/0", BCEN, BCdata, BClabel, grant_idx);
        end
        n_cmp++;
        if (requireAC !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL reset_ac: got %b expected 0001", requireAC);
        end
        nRST = 1'b1;
        run_cycle(4'b1111, d, {4'd4, 4'd3, 4'd2, 4'd9}, oac, eac);
        n_cmp++;
        if (oac !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL first_grant: got %b expected 0001", oac);
        end
        n_cmp++;
        if ({BCEN, BClabel, grant_idx} !== {1'b1, 4'd9, 2'd0}) begin
            n_fail++;
            $display("[TB] FAIL first_bcast: got %b/%0d/%0d expected 1/9/0", BCEN, BClabel, grant_idx);
        end
    endtask

    task automatic test_round_robin();
        logic [N_REQ-1:0] oac, eac;
        logic [N_REQ*DATA_W-1:0]  d;
        logic [N_REQ*LABEL_W-1:0] l;
        int exp_lab [5] = '{1, 2, 3, 4, 1};
        d = {32'h40, 32'h30, 32'h20, 32'h10};
        l = {4'd4, 4'd3, 4'd2, 4'd1};
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            run_cycle(4'b1111, d, l, oac, eac);
            n_cmp++;
            if (oac !== eac) begin
                n_fail++;
                $display("[TB] FAIL rr_ac[%0d]: got %b expected %b", c, oac, eac);
            end
            n_cmp++;
            if ({BCEN, BClabel, BCdata} !== {1'b1, 4'(exp_lab[c]), 32'(exp_lab[c] * 16)}) begin
                n_fail++;
                $display("[TB] FAIL rr_bcast[%0d]: got %b/%0d/%h expected 1/%0d/%h", c, BCEN, BClabel, BCdata, exp_lab[c], exp_lab[c] * 16);
            end
        end
    endtask

    task automatic test_single();
        logic [N_REQ-1:0] oac, eac;
        logic [N_REQ*DATA_W-1:0]  d;
        logic [N_REQ*LABEL_W-1:0] l;
        d = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
        l = {4'd0, 4'd7, 4'd0, 4'd0};
        run_cycle(4'b0100, d, l, oac, eac);
        n_cmp++;
        if (oac !== 4'b0100) begin
            n_fail++;
            $display("[TB] FAIL single_ac: got %b expected 0100", oac);
        end
        n_cmp++;
        if ({BCEN, BCdata, BClabel, grant_idx} !== {1'b1, 32'hDEADBEEF, 4'd7, 2'd2}) begin
            n_fail++;
            $display("[TB] FAIL single_bcast: got %b/%h/%0d/%0d expected 1/deadbeef/7/2", BCEN, BCdata, BClabel, grant_idx);
        end
        run_cycle(4'b0000, d, l, oac, eac);
        n_cmp++;
        if ({BCEN, BCdata, BClabel, grant_idx} !== {1'b0, 32'hDEADBEEF, 4'd7, 2'd2}) begin
            n_fail++;
            $display("[TB] FAIL single_drop: got %b/%h/%0d/%0d expected 0/deadbeef/7/2", BCEN, BCdata, BClabel, grant_idx);
        end
    endtask

    task automatic test_label_zero();
        logic [N_REQ-1:0] oac, eac;
        logic [N_REQ*DATA_W-1:0] d;
        d = {32'h4, 32'h3, 32'h55, 32'h11};
        for (int c = 0; c < 2; c++) begin
            run_cycle(4'b0001, d, 16'h0000, oac, eac);
            n_cmp++;
            if (oac !== 4'b0000 || BCEN !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL label0[%0d]: got ac=%b bcen=%b expected ac=0000 bcen=0", c, oac, BCEN);
            end
        end
        run_cycle(4'b0011, d, {4'd0, 4'd0, 4'd5, 4'd0}, oac, eac);
        n_cmp++;
        if (oac !== 4'b0010) begin
            n_fail++;
            $display("[TB] FAIL label0_add_ac: got %b expected 0010", oac);
        end
        n_cmp++;
        if ({BCEN, BCdata, BClabel, grant_idx} !== {1'b1, 32'h55, 4'd5, 2'd1}) begin
            n_fail++;
            $display("[TB] FAIL label0_add_bcast: got %b/%h/%0d/%0d expected 1/55/5/1", BCEN, BCdata, BClabel, grant_idx);
        end
    endtask

    task automatic test_async_reset();
        logic [N_REQ-1:0] oac, eac;
        logic [N_REQ*DATA_W-1:0]  d;
        logic [N_REQ*LABEL_W-1:0] l;
        d = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
        l = {4'd4, 4'd3, 4'd2, 4'd1};
        run_cycle(4'b0001, d, l, oac, eac);
        #2;
        nRST = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({BCEN, BCdata, BClabel, grant_idx} !== 39'd0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %b/%h/%0d/%0d expected 0/0/0/0", BCEN, BCdata, BClabel, grant_idx);
        end
        @(posedge clk);
        #1;
        nRST = 1'b1;
        run_cycle(4'b1111, d, l, oac, eac);
        n_cmp++;
        if (oac !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL async_ptr: got %b expected 0001", oac);
        end
    endtask

    task automatic test_random();
        logic [N_REQ-1:0] oac, eac, req;
        logic [N_REQ*DATA_W-1:0]  d;
        logic [N_REQ*LABEL_W-1:0] l;
        for (int c = 0; c < 300; c++) begin
            req = 4'($urandom);
            for (int i = 0; i < N_REQ; i++) begin
                d[i*DATA_W +: DATA_W]   = $urandom;
                l[i*LABEL_W +: LABEL_W] = 4'($urandom_range(0, 15));
            end
            run_cycle(req, d, l, oac, eac);
            n_cmp++;
            if (oac !== eac) begin
                n_fail++;
                $display("[TB] FAIL rand_ac[%0d]: got %b expected %b", c, oac, eac);
            end
            n_cmp++;
            if ({BCEN, BCdata, BClabel, grant_idx} !== {m_bcen, m_data, m_label, m_gidx}) begin
                n_fail++;
                $display("[TB] FAIL rand_bcast[%0d]: got %b/%h/%0d/%0d expected %b/%h/%0d/%0d", c, BCEN, BCdata, BClabel, grant_idx, m_bcen, m_data, m_label, m_gidx);
            end
        end
    endtask

`ifdef CDB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        logic [N_REQ-1:0] oac, eac;
        for (int c = 0; c < 6; c++) begin
            run_cycle(4'b1001, {32'h9, 32'h0, 32'h0, 32'h1}, {4'd9, 4'd0, 4'd0, 4'd1}, oac, eac);
            n_cmp++;
            if (oac !== 4'b0001 || grant_idx !== 2'd0) begin
                n_fail++;
                $display("[TB] FAIL fixed_prio[%0d]: got ac=%b gidx=%0d expected ac=0001 gidx=0", c, oac, grant_idx);
            end
        end
    endtask
`endif

    initial begin
        $display("[TB] starting cdb_arbiter bench");
        test_reset();
`ifndef CDB_FIXED_PRIO_EN
        test_round_robin();
`endif
        test_single();
        test_label_zero();
        test_async_reset();
        test_random();
`ifdef CDB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Registered round-robin arbiter and broadcast stage for the common data bus (CDB) of the Tomasulo core. It collects result requests from the functional units: ALU, multiplier, divider and load/store memory. Each cycle it grants at most one of them and drives the granted unit's result and reservation-station label onto the CDB one cycle later. It replaces combinational fixed-priority arbitration so that no functional unit can be starved and the CDB outputs come from flops.

## Interface
- `N_REQ`, 4, number of requesters; index 0 = ALU, 1 = mul, 2 = div, 3 = load/store.
- `DATA_W`, 32, result width.
- `LABEL_W`, 4, reservation-station label width; label value 0 means "no producer".
- `clk`  input  1  clock; all state updates on the rising edge.
- `nRST`  input  1  reset, asynchronous, active-low.
- `require`  input  N_REQ  per-unit request; held high until accepted.
- `data_in`  input  N_REQ*DATA_W  flattened results; slice i is `[i*DATA_W +: DATA_W]`.
- `label_in`  input  N_REQ*LABEL_W  flattened labels; slice i is `[i*LABEL_W +: LABEL_W]`.
- `requireAC`  output  N_REQ  one-hot grant; combinational in the request cycle.
- `BCEN`  output  1  broadcast valid, registered.
- `BCdata`  output  DATA_W  broadcast result, registered.
- `BClabel`  output  LABEL_W  broadcast label, registered.
- `grant_idx`  output  2  index of the last granted requester, registered.

## Operation
- Eligible requester: `require[i]=1` and `label_in` slice i ≠ 0.
  - A request carrying label 0 is never granted.
  - It produces no broadcast and stays pending; the requester must clear it.
- Arbitration is combinational over eligible requesters, starting from pointer `ptr` (2 bits) and searching upward modulo N_REQ.
  - The first eligible index wins.
  - `requireAC` is one-hot on the winner, all-zero if none.
- Grant handshake:
  - The requester samples `requireAC[i]=1` at the rising edge.
  - At that edge it deasserts `require[i]` or presents its next result.
  - `data_in`/`label_in` must be stable in the grant cycle only.
- On the edge closing a grant cycle with winner w:
  - `BCEN<=1`, `BCdata<=data_in[w]`, `BClabel<=label_in[w]`.
  - `grant_idx<=w`.
  - `ptr<=(w+1) mod N_REQ`.
- Cycle with no winner: `BCEN<=0`; `BCdata`, `BClabel`, `grant_idx` and `ptr` hold their values.
- Any requester continuously requesting is granted within N_REQ cycles.
- Reset: `ptr=0`, `BCEN=0`, `BCdata=0`, `BClabel=0`, `grant_idx=0`.
  - Asserting reset mid-broadcast clears `BCEN` immediately.
  - `requireAC` follows its combinational inputs and is all-zero when `require=0`.

## Timing
- Request to grant: 0 cycles (same cycle).
- Grant to broadcast: 1 cycle; `BCEN` is high for exactly one cycle per grant.
- Throughput: one broadcast per cycle; back-to-back grants give `BCEN` continuously high.
- A unit granted in cycle t sees its own label broadcast in cycle t+1.
  - Reservation stations and the register file latch `BCdata` at the end of t+1.
- Simultaneous requests from all units:
  - From `ptr=0`, grant order is 0,1,2,3.
  - The pointer wraps from 3 to 0.
- `require` rising in the same cycle as the pointer moves is arbitrated against the new `ptr` value.

## Configuration
- `CDB_FIXED_PRIO_EN` defined:
  - `ptr` is tied to 0, giving fixed priority with lowest index highest.
  - All other behaviour (registered broadcast, label-0 rule, reset values) is unchanged.
  - Starvation of high indices is possible and accepted.
- Not defined: round-robin as specified above.

## Test plan
- Reset with `require=4'b1111`, release `nRST`:
  - `BCEN=0` during reset.
  - First edge after release grants index 0.
  - Next cycle `BCEN=1`, `BClabel=label0`, `grant_idx=0`.
- All four units requesting continuously with labels 1,2,3,4 and data 0x10,0x20,0x30,0x40:
  - Broadcasts in order (1,0x10), (2,0x20), (3,0x30), (4,0x40), (1,0x10).
  - `BCEN` stays high throughout.
- Single request `require=4'b0100`, label 7, data 0xDEADBEEF:
  - `requireAC=4'b0100` in the same cycle.
  - Next cycle `BCEN=1`, `BCdata=0xDEADBEEF`, `BClabel=7`.
  - The following cycle `BCEN=0` after the request drops.
- Request `require=4'b0001` with label 0:
  - `requireAC=0`, `BCEN` never asserts.
  - Adding `require[1]` with label 5 grants index 1.
- `nRST` asserted asynchronously mid-cycle while `BCEN=1`:
  - `BCEN`, `BCdata`, `BClabel` go to 0 without waiting for a clock edge.
  - `ptr` returns to 0.
- With `CDB_FIXED_PRIO_EN`, units 0 and 3 requesting continuously:
  - Index 0 is granted every cycle.
  - `requireAC[3]` stays 0.
